// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (0=CPU, 1=loader) arbiter onto one fixed-LAT memory; per port req/we/addr/wdata in, gnt/ack/rdata out; mem_en/we/addr/wdata/rdata bus; busy
module mem_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_owner, cmd_we, accept, sel;
  always_comb begin
    accept = (state == IDLE || state == DONE) && (req0 || req1);
    sel = (req0 && req1) ? !last_owner : req1;
    state_nx = state == ISSUE ? (cmd_we ? DONE : WAIT) :
               state == WAIT ? (cnt == 4'd1 ? DONE : WAIT) :
               accept ? ISSUE : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en && cmd_we;
    gnt0 = mem_en && !last_owner;
    gnt1 = mem_en && last_owner;
    ack0 = state == DONE && !last_owner;
    ack1 = state == DONE && last_owner;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      last_owner <= 1'b1;
      cmd_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (accept) begin
        last_owner <= sel;
        cmd_we <= sel ? we1 : we0;
        mem_addr <= sel ? addr1 : addr0;
        mem_wdata <= sel ? wdata1 : wdata0;
      end
      if (state == ISSUE) cnt <= 4'(LAT);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == WAIT && cnt == 4'd1 && !last_owner) rdata0 <= mem_rdata;
      if (state == WAIT && cnt == 4'd1 && last_owner) rdata1 <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-timeline model
module tb_mem_port_arbiter;
  localparam int LAT2 = 2;
  localparam int MAXC = 700;
  logic clk, rst;
  logic req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic gnt0_l, gnt1_l, ack0_l, ack1_l, mem_en_l, mem_we_l, busy_l;
  logic [31:0] rdata0_l, rdata1_l, mem_addr_l, mem_wdata_l, mem_rdata_l;
  logic [31:0] p2 [2];
  logic [31:0] p15 [15];
  logic [31:0] rseed;
  int vec, errs;
  logic [1:0] e_gnt [MAXC];
  logic [1:0] e_ack [MAXC];
  logic e_men [MAXC];
  logic e_mwe [MAXC];
  logic e_busy [MAXC];
  logic [31:0] e_maddr [MAXC];
  logic [31:0] e_mwd [MAXC];
  logic [31:0] e_rd0 [MAXC];
  logic [31:0] e_rd1 [MAXC];

  mem_port_arbiter #(.DW(32), .AW(32), .LAT(LAT2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.DW(32), .AW(32), .LAT(15)) dut_l (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_l), .gnt1(gnt1_l), .ack0(ack0_l), .ack1(ack1_l), .rdata0(rdata0_l), .rdata1(rdata1_l),
    .mem_en(mem_en_l), .mem_we(mem_we_l), .mem_addr(mem_addr_l), .mem_wdata(mem_wdata_l),
    .mem_rdata(mem_rdata_l), .busy(busy_l));

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ rseed;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    p2[0] <= (mem_en && !mem_we) ? mem_init(mem_addr) : '0;
    p2[1] <= p2[0];
    p15[0] <= (mem_en_l && !mem_we_l) ? (mem_addr_l ^ 32'h5A5A0000) : '0;
    for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
  end
  assign mem_rdata = p2[1];
  assign mem_rdata_l = p15[14];

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #2 rst = 1;
    #1;
    vec++;
    if ({gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata0, rdata1} !== '0)
      begin errs++; $display("FAIL reset_lat2: outputs %b %b %b %b %b %b %b %h %h %h %h, want all 0",
        gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata0, rdata1); end
    vec++;
    if ({gnt0_l, gnt1_l, ack0_l, ack1_l, mem_en_l, mem_we_l, busy_l, mem_addr_l, mem_wdata_l, rdata0_l, rdata1_l} !== '0)
      begin errs++; $display("FAIL reset_lat15: outputs not all 0 (busy=%b addr=%h)", busy_l, mem_addr_l); end
  endtask

  task automatic test_read0();
    logic [6:0] ex;
    do_reset();
    req0 = 1; addr0 = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 0;
      ex = {c == 1, 1'b0, c == 1, 1'b0, c == 4, 1'b0, c <= 4};
      vec++;
      if ({gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy} !== ex)
        begin errs++; $display("FAIL read0 cycle %0d: gnt/en/we/ack/busy %b, want %b", c,
          {gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy}, ex); end
      if (c == 1) begin
        vec++;
        if (mem_addr !== 32'h40) begin errs++; $display("FAIL read0 mem_addr %h, want 00000040", mem_addr); end
      end
      if (c == 4) begin
        vec++;
        if (rdata0 !== 32'hDEADBEEF) begin errs++; $display("FAIL read0 rdata0 %h, want deadbeef", rdata0); end
      end
    end
  endtask

  task automatic test_write1();
    logic [6:0] ex;
    do_reset();
    req1 = 1; we1 = 1; addr1 = 32'h80; wdata1 = 32'h12345678;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) req1 = 0;
      ex = {1'b0, c == 1, c == 1, c == 1, 1'b0, c == 2, c <= 2};
      vec++;
      if ({gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy} !== ex)
        begin errs++; $display("FAIL write1 cycle %0d: gnt/en/we/ack/busy %b, want %b", c,
          {gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy}, ex); end
      if (c == 1) begin
        vec++;
        if ({mem_addr, mem_wdata} !== {32'h80, 32'h12345678})
          begin errs++; $display("FAIL write1 bus addr=%h data=%h, want 00000080 12345678", mem_addr, mem_wdata); end
      end
      if (c == 2) begin
        vec++;
        if (rdata1 !== 32'h0) begin errs++; $display("FAIL write1 rdata1 %h, want 00000000", rdata1); end
      end
    end
  endtask

  task automatic test_tie();
    logic [6:0] ex;
    do_reset();
    req0 = 1; addr0 = 32'h40; req1 = 1; addr1 = 32'h44;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 0;
      if (c == 5) req1 = 0;
      ex = {c == 1, c == 5, c == 1 || c == 5, 1'b0, c == 4, c == 8, c <= 8};
      vec++;
      if ({gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy} !== ex)
        begin errs++; $display("FAIL tie cycle %0d: gnt/en/we/ack/busy %b, want %b", c,
          {gnt0, gnt1, mem_en, mem_we, ack0, ack1, busy}, ex); end
      if (c == 8) begin
        vec++;
        if ({rdata0, rdata1} !== {32'hDEADBEEF, mem_init(32'h44)})
          begin errs++; $display("FAIL tie rdata %h %h, want deadbeef %h", rdata0, rdata1, mem_init(32'h44)); end
      end
    end
  endtask

  task automatic test_random(input int ncyc, input int pct, input bit wonly, input bit chk_alt);
    int nacc, w, g, a, lastg, cur;
    bit lo;
    bit pend [2];
    bit pwe [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [31:0] rv;
    logic [134:0] got, want;
    for (int c = 0; c < MAXC; c++) begin
      e_gnt[c] = '0; e_ack[c] = '0; e_men[c] = 0; e_mwe[c] = 0; e_busy[c] = 0;
      e_maddr[c] = '0; e_mwd[c] = '0; e_rd0[c] = '0; e_rd1[c] = '0;
    end
    do_reset();
    nacc = 0; lo = 1; lastg = -1;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; pwe[p] = 0; pa[p] = '0; pd[p] = '0; end
    for (int k = 0; k < ncyc + 24; k++) begin
      @(posedge clk); #1;
      got = {gnt1, gnt0, ack1, ack0, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata0, rdata1};
      want = {e_gnt[k], e_ack[k], e_men[k], e_mwe[k], e_busy[k], e_maddr[k], e_mwd[k], e_rd0[k], e_rd1[k]};
      vec++;
      if (got !== want) begin errs++; $display("FAIL rand cycle %0d: got %h want %h", k, got, want); end
      if (chk_alt && (gnt0 || gnt1)) begin
        cur = gnt1 ? 1 : 0;
        if (lastg >= 0) begin
          vec++;
          if (cur == lastg || (gnt0 && gnt1))
            begin errs++; $display("FAIL alternate cycle %0d: gnt0=%b gnt1=%b after port %0d", k, gnt0, gnt1, lastg); end
        end
        lastg = cur;
      end
      for (int p = 0; p < 2; p++) begin
        if (e_gnt[k][p]) pend[p] = 0;
        if (!pend[p] && k < ncyc && int'($urandom_range(99)) < pct) begin
          pend[p] = 1;
          pwe[p] = wonly || ($urandom_range(1) == 1);
          pa[p] = 32'h100 + 32'(4 * $urandom_range(7));
          pd[p] = $urandom;
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
      if (k == nacc) begin
        if (pend[0] || pend[1]) begin
          w = (pend[0] && pend[1]) ? (lo ? 0 : 1) : (pend[1] ? 1 : 0);
          lo = (w == 1);
          g = k + 1;
          a = g + (pwe[w] ? 1 : LAT2 + 1);
          e_gnt[g][w] = 1'b1; e_men[g] = 1; e_mwe[g] = pwe[w]; e_ack[a][w] = 1'b1;
          for (int c = g; c <= a; c++) e_busy[c] = 1;
          for (int c = g; c < MAXC; c++) begin e_maddr[c] = pa[w]; e_mwd[c] = pd[w]; end
          rv = mem_init(pa[w]);
          if (!pwe[w]) for (int c = a; c < MAXC; c++) if (w == 1) e_rd1[c] = rv; else e_rd0[c] = rv;
          nacc = a;
        end else nacc = k + 1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    test_random(100, 100, 1, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1; addr0 = 32'h40;
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    vec++;
    if (busy !== 1'b1) begin errs++; $display("FAIL rstmid busy before reset %b, want 1", busy); end
    rst = 1;
    #1;
    vec++;
    if ({gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata0, rdata1} !== '0)
      begin errs++; $display("FAIL rstmid async: busy=%b ack0=%b addr=%h, want all 0", busy, ack0, mem_addr); end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      vec++;
      if ({ack0, ack1, busy} !== 3'b000)
        begin errs++; $display("FAIL rstmid after release cycle %0d: ack0=%b ack1=%b busy=%b, want 0", c, ack0, ack1, busy); end
    end
    req0 = 1; req1 = 1; addr1 = 32'h44;
    @(posedge clk); #1;
    vec++;
    if ({gnt0, gnt1} !== 2'b10) begin errs++; $display("FAIL rstmid tie gnt0/gnt1 %b%b, want 10", gnt0, gnt1); end
    idle_inputs();
  endtask

  task automatic test_lat15();
    do_reset();
    req0 = 1; addr0 = 32'h200;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 0;
      vec++;
      if ({gnt0_l, mem_en_l, ack0_l, ack1_l} !== {c == 1, c == 1, c == 17, 1'b0})
        begin errs++; $display("FAIL lat15 cycle %0d: gnt0/en/ack0/ack1 %b%b%b%b, want %b%b%b0", c,
          gnt0_l, mem_en_l, ack0_l, ack1_l, c == 1, c == 1, c == 17); end
      if (c == 17) begin
        vec++;
        if (rdata0_l !== (32'h200 ^ 32'h5A5A0000))
          begin errs++; $display("FAIL lat15 rdata0 %h, want %h", rdata0_l, 32'h200 ^ 32'h5A5A0000); end
      end
    end
  endtask

  initial begin
    vec = 0; errs = 0;
    rseed = $urandom;
    test_reset();
    test_read0();
    test_write1();
    test_tie();
    test_back_to_back();
    test_random(400, 35, 0, 0);
    test_reset_mid();
    test_lat15();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DW, 32, data width.
REQ-002 SHALL have parameter AW, 32, byte address width.
REQ-003 SHALL have parameter LAT, 2, fixed memory read latency in cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports req0/req1  input  1  access request, port 0 = CPU, port 1 = loader/debug.
REQ-007 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1  input  AW  access address.
REQ-009 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: command accepted.
REQ-011 SHALL have ports ack0/ack1  output  1  one-cycle pulse: access complete.
REQ-012 SHALL have ports rdata0/rdata1  output  DW  read data, valid with ack.
REQ-013 SHALL have port mem_en  output  1  memory access strobe.
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_addr  output  AW  memory address.
REQ-016 SHALL have port mem_wdata  output  DW  memory write data.
REQ-017 SHALL have port mem_rdata  input  DW  memory read data, valid LAT cycles after the mem_en cycle.
REQ-018 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 In IDLE or DONE, if any req is sampled high, SHALL select owner, latch that port's we/addr/wdata, and go to ISSUE; otherwise go to IDLE.
REQ-021 Selection: a single requester wins; on a tie, the port differing from last_owner wins.
REQ-022 last_owner SHALL update on every entry to ISSUE.
REQ-023 ISSUE (exactly one cycle) SHALL drive mem_en=1, mem_we/mem_addr/mem_wdata from latched command, and the owner's gnt=1.
REQ-024 From ISSUE, a write SHALL go to DONE; a read SHALL load a 4-bit counter with LAT and go to WAIT.
REQ-025 WAIT SHALL decrement the counter each cycle; when counter==1, SHALL capture mem_rdata into the owner's rdata register and go to DONE.
REQ-026 Read timing: mem_en in cycle c, then ack in cycle c+LAT+1; write timing: ack in cycle c+1.
REQ-027 DONE SHALL pulse the owner's ack for one cycle; the non-owner's ack SHALL stay 0.
REQ-028 rdata0/rdata1 SHALL hold their last captured value until the next read completion for that port; writes SHALL not alter them.
REQ-029 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last driven value.
REQ-030 Requester contract: hold req and command stable until gnt; any req high sampled in IDLE/DONE is a new request; the requester drops req the cycle after gnt unless it has another command.
REQ-031 Back-to-back: DONE->ISSUE without an IDLE cycle; with both ports requesting continuously, grants SHALL strictly alternate.
REQ-032 At most one gnt and one ack SHALL be high in any cycle.

Reset
REQ-033 On rst high, asynchronously: state=IDLE, counter=0, last_owner=1, all gnt/ack/mem_en/mem_we/busy=0, mem_addr/mem_wdata/rdata0/rdata1=0.
REQ-034 Reset mid-transaction SHALL drop the access with no ack issued afterwards; the first tie after reset goes to port 0.

Verification (LAT=2)
REQ-035 Port 0 read of addr 0x40, alone, req sampled at edge 0 -> gnt0 and mem_en cycle 1 with mem_addr=0x40; mem_rdata=0xDEADBEEF cycle 3 -> ack0=1, rdata0=0xDEADBEEF cycle 4.
REQ-036 Port 1 write addr 0x80 data 0x12345678 -> gnt1 with mem_we=1 cycle 1, ack1 cycle 2, rdata1 unchanged.
REQ-037 req0 and req1 both high at edge 0 immediately after reset, both reads -> gnt0 cycle 1, ack0 cycle 4, gnt1 cycle 5, ack1 cycle 8.
REQ-038 Both ports issue continuous back-to-back writes -> grants alternate 0,1,0,1 every 2 cycles; never two gnts in one cycle.
REQ-039 rst pulsed in WAIT of a port 0 read -> all outputs 0 immediately, no ack0 after release; the next tie grants port 0.
REQ-040 LAT=15 read -> ack exactly 16 cycles after the mem_en cycle.
